load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_lane_align.sv | 65 ++++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, response error codes and FSM states.
// The RMW_RD state exists only when LSU_RMW_EN is defined.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  localparam logic [1:0] ERR_UNSUP    = 2'd3;

`ifdef LSU_RMW_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } lsu_state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_t;
`endif

  // Reserved size is reported as misaligned rather than as a separate error.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends load data, and merges
// sub-word store data into the word read from memory.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select and sign/zero extension for loads
  always_comb begin
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    if (addr_lo[1]) begin
      half_lane = rdata[31:16];
    end else begin
      half_lane = rdata[15:0];
    end
    case (size)
      SIZE_BYTE: load_data = is_unsigned ? {24'h000000, byte_lane}
                                         : {{24{byte_lane[7]}}, byte_lane};
      SIZE_HALF: load_data = is_unsigned ? {16'h0000, half_lane}
                                         : {{16{half_lane[15]}}, half_lane};
      default:   load_data = rdata;
    endcase
  end

  // Store merge: only the addressed lane takes new data
  always_comb begin
    merged = rdata;
    case (size)
      SIZE_BYTE: begin
        case (addr_lo)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          2'd3:    merged[31:24] = wdata[7:0];
          default: merged[7:0]   = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (addr_lo[1]) begin
          merged[31:16] = wdata[15:0];
        end else begin
          merged[15:0] = wdata[15:0];
        end
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-addressed data memory.
// Define LSU_RMW_EN to support sub-word stores via read-modify-write; otherwise they return err 3.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  lsu_state_t  state;
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        accept;
  logic        misaligned;
  logic        out_of_range;

  assign req_ready    = (state == IDLE) && !rst;
  assign accept       = req_valid && req_ready;
  assign misaligned   = is_misaligned(req_size, req_addr[1:0]);
  assign out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS_W);

  lsu_lane_align u_lane_align (
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .addr_lo     (addr_q[1:0]),
    .rdata       (mem_rdata),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  // State decode goes low with the asynchronous state reset, so a write is cut off at once.
  assign mem_we   = (state == WR);
  assign mem_addr = {addr_q[31:2], 2'b00};

`ifdef LSU_RMW_EN
  logic [31:0] merged_q;
  assign mem_wdata = (size_q == SIZE_WORD) ? wdata_q : merged_q;
`else
  assign mem_wdata = (size_q == SIZE_WORD) ? wdata_q : merged;
`endif

  // Request FSM with registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= ERR_OK;
`ifdef LSU_RMW_EN
      merged_q   <= 32'h0000_0000;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            write_q    <= req_write;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            resp_rdata <= 32'h0000_0000;
            if (misaligned) begin
              resp_err   <= ERR_MISALIGN;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (out_of_range) begin
              resp_err   <= ERR_RANGE;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (!req_write) begin
              resp_err <= ERR_OK;
              state    <= RD;
            end else if (req_size == SIZE_WORD) begin
              resp_err <= ERR_OK;
              state    <= WR;
            end else begin
`ifdef LSU_RMW_EN
              resp_err <= ERR_OK;
              state    <= RMW_RD;
`else
              resp_err   <= ERR_UNSUP;
              resp_valid <= 1'b1;
              state      <= RESP;
`endif
            end
          end else begin
            state <= IDLE;
          end
        end
        RD: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
`ifdef LSU_RMW_EN
        RMW_RD: begin
          merged_q <= merged;
          state    <= WR;
        end
`endif
        WR: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end else begin
            state <= RESP;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
